// File: rtl/gesummv_pkg.sv
// Shared constants and types for the gesummv result drain.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gesummv_pkg;

    localparam int DRAIN_DEPTH  = 8;
    localparam int DRAIN_ADDR_W = $clog2(DRAIN_DEPTH);
    localparam int DRAIN_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } drain_state_t;

    // Sticky error flag positions
    localparam int ERR_DUP_BIT = 0;  // same entry written twice in one collection
    localparam int ERR_OOC_BIT = 1;  // write arrived while not collecting

endpackage

// File: rtl/gesummv_drain_buf.sv
// Result register file with per-entry written bitmap, one write port, one async read port.
// Latency: write visible on read port the cycle after wr_en; all_written looks ahead by one write.
// Backpressure: none; the caller gates wr_en.
module gesummv_drain_buf #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_hit,
    output logic              all_written
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;
    logic [DEPTH-1:0]  wr_mask;

    assign wr_mask = {{(DEPTH-1){1'b0}}, 1'b1} << wr_addr;

    // Entry storage carries no reset; validity is tracked by the bitmap alone
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Written bitmap: clear wins over a same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written <= '0;
        end else if (clear) begin
            written <= '0;
        end else if (wr_en) begin
            written <= written | wr_mask;
        end
    end

    assign rd_data     = mem[rd_addr];
    assign wr_hit      = |(written & wr_mask);
    // Includes this cycle's write so the drain can start on the next edge
    assign all_written = &(written | (wr_en ? wr_mask : {DEPTH{1'b0}}));

endmodule

// File: rtl/gesummv_result_drain.sv
// Collects the kernel's result-vector writes, then streams entries 0..DEPTH-1 out in order.
// Latency: first word valid the cycle after the completing write; one word per cycle when ready.
// Backpressure: out_ready low holds out_data/out_index/out_last; no comb path ready->valid.
// Optional checksum accumulator enabled by GESUMMV_DRAIN_CHECKSUM_EN.
module gesummv_result_drain
    import gesummv_pkg::*;
#(
    parameter int DEPTH  = DRAIN_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = DRAIN_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tstart,
    input  logic [ADDR_W-1:0] res_addr,
    input  logic              res_wr_en,
    input  logic [DATA_W-1:0] res_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [DATA_W-1:0] checksum
);

    drain_state_t      state;
    logic              buf_wr_en;
    logic              wr_hit;
    logic              all_written;
    logic [DATA_W-1:0] rd_data;
    logic              beat;

    // tstart takes priority, so a same-cycle write never lands in the new collection
    assign buf_wr_en = res_wr_en && (state == ST_COLLECT) && !tstart;
    assign beat      = out_valid && out_ready;

    gesummv_drain_buf #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (tstart),
        .wr_en       (buf_wr_en),
        .wr_addr     (res_addr),
        .wr_data     (res_wr_data),
        .rd_addr     (out_index),
        .rd_data     (rd_data),
        .wr_hit      (wr_hit),
        .all_written (all_written)
    );

    // Forced to zero outside a drain so idle/reset shows a clean bus
    assign out_data = out_valid ? rd_data : '0;

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= '0;
        end else begin
            done <= 1'b0;
            if (tstart) begin
                state     <= ST_COLLECT;
                out_valid <= 1'b0;
                out_index <= '0;
                out_last  <= 1'b0;
                busy      <= 1'b1;
                err       <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (res_wr_en) begin
                            err[ERR_OOC_BIT] <= 1'b1;
                        end
                    end
                    ST_COLLECT: begin
                        if (res_wr_en && wr_hit) begin
                            err[ERR_DUP_BIT] <= 1'b1;
                        end
                        if (res_wr_en && all_written) begin
                            state     <= ST_DRAIN;
                            out_valid <= 1'b1;
                            out_index <= '0;
                            out_last  <= (DEPTH == 1);
                        end
                    end
                    ST_DRAIN: begin
                        if (res_wr_en) begin
                            err[ERR_OOC_BIT] <= 1'b1;
                        end
                        if (beat) begin
                            if (out_last) begin
                                state     <= ST_IDLE;
                                out_valid <= 1'b0;
                                out_index <= '0;
                                out_last  <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                out_index <= out_index + 1'b1;
                                out_last  <= (out_index == ADDR_W'(DEPTH - 2));
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef GESUMMV_DRAIN_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    // Running sum of accepted words; wraps modulo 2^DATA_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (tstart) begin
            csum <= '0;
        end else if (beat) begin
            csum <= csum + out_data;
        end
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_gesummv_result_drain.sv
// Scoreboard bench for gesummv_result_drain: expected beats are queued as writes are
// driven and popped as the DUT streams them out.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_gesummv_result_drain;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] dat;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tstart = 1'b0;
    logic [ADDR_W-1:0] res_addr = '0;
    logic              res_wr_en = 1'b0;
    logic [DATA_W-1:0] res_wr_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [1:0]        err;
    logic [DATA_W-1:0] checksum;

    int    tests_run    = 0;
    int    tests_failed = 0;
    beat_t exp_q[$];
    logic [DATA_W-1:0] exp_sum;

    always #5 clk = ~clk;

    gesummv_result_drain dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tstart      (tstart),
        .res_addr    (res_addr),
        .res_wr_en   (res_wr_en),
        .res_wr_data (res_wr_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .checksum    (checksum)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        tstart = 1'b1;
        tick();
        tstart = 1'b0;
        exp_q.delete();
        exp_sum = '0;
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d);
        res_wr_en   = 1'b1;
        res_addr    = ADDR_W'(a);
        res_wr_data = d;
        tick();
        res_wr_en   = 1'b0;
    endtask

    // Drive out_ready from a 4-cycle pattern and check every beat against the queue
    task automatic run_drain(input logic [3:0] rdy_pat, input string name);
        int                cyc;
        int                beats;
        bit                stalled;
        bit                finished;
        logic [DATA_W-1:0] hold_dat;
        logic [ADDR_W-1:0] hold_idx;
        beat_t             e;
        cyc = 0; beats = 0; stalled = 1'b0; finished = 1'b0;
        hold_dat = '0; hold_idx = '0;
        while (!finished && cyc < 200) begin
            out_ready = rdy_pat[cyc % 4];
            if (stalled) begin
                tests_run++;
                if (out_data !== hold_dat || out_index !== hold_idx || out_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s_hold: idx %0d dat %0d vld %b, required idx %0d dat %0d vld 1",
                             name, out_index, out_data, out_valid, hold_idx, hold_dat);
                end
            end
            stalled = out_valid && !out_ready;
            hold_dat = out_data;
            hold_idx = out_index;
            if (out_valid && out_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL %s_extra: unexpected beat idx %0d dat %0d, required none",
                             name, out_index, out_data);
                end else begin
                    e = exp_q.pop_front();
                    exp_sum = exp_sum + e.dat;
                    if (out_index !== e.idx || out_data !== e.dat ||
                        out_last !== (e.idx == ADDR_W'(DEPTH - 1))) begin
                        tests_failed++;
                        $display("FAIL %s_beat: idx %0d dat %0d last %b, required idx %0d dat %0d last %b",
                                 name, out_index, out_data, out_last, e.idx, e.dat,
                                 (e.idx == ADDR_W'(DEPTH - 1)));
                    end
                end
                beats++;
                if (out_last) finished = 1'b1;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        tests_run++;
        if (!finished || beats != DEPTH || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_count: beats %0d finished %b left %0d, required beats %0d finished 1 left 0",
                     name, beats, finished, exp_q.size(), DEPTH);
        end
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_done: done %b busy %b vld %b, required done 1 busy 0 vld 0",
                     name, done, busy, out_valid);
        end
        tests_run++;
`ifdef GESUMMV_DRAIN_CHECKSUM_EN
        if (checksum !== exp_sum) begin
            tests_failed++;
            $display("FAIL %s_checksum: got %0d, required %0d", name, checksum, exp_sum);
        end
`else
        if (checksum !== '0) begin
            tests_failed++;
            $display("FAIL %s_checksum: got %0d, required 0", name, checksum);
        end
`endif
        tick();
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_done_pulse: done %b, required 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_index !== '0 || out_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 2'b00 || checksum !== '0) begin
            tests_failed++;
            $display("FAIL reset: vld %b dat %0d idx %0d last %b busy %b done %b err %b sum %0d, required all 0",
                     out_valid, out_data, out_index, out_last, busy, done, err, checksum);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_in_order();
        start();
        tests_run++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL in_order_start: busy %b vld %b, required busy 1 vld 0", busy, out_valid);
        end
        for (int i = 0; i < DEPTH; i++) begin
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL in_order_early: vld %b before write %0d, required 0", out_valid, i);
            end
            wr(i, DATA_W'(10 * i + 1));
            exp_q.push_back('{idx: ADDR_W'(i), dat: DATA_W'(10 * i + 1)});
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_index !== '0 || out_data !== 32'd1) begin
            tests_failed++;
            $display("FAIL in_order_first: vld %b idx %0d dat %0d, required vld 1 idx 0 dat 1",
                     out_valid, out_index, out_data);
        end
        run_drain(4'b1111, "in_order");
`ifdef GESUMMV_DRAIN_CHECKSUM_EN
        tests_run++;
        if (exp_sum !== 32'd288) begin
            tests_failed++;
            $display("FAIL in_order_sum288: scoreboard sum %0d, required 288", exp_sum);
        end
`endif
    endtask

    task automatic test_shuffled();
        int order [8] = '{7, 3, 0, 5, 1, 6, 2, 4};
        start();
        for (int i = 0; i < DEPTH; i++) begin
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL shuffled_early: vld %b before write of addr %0d, required 0",
                         out_valid, order[i]);
            end
            wr(order[i], DATA_W'(order[i]));
        end
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('{idx: ADDR_W'(i), dat: DATA_W'(i)});
        run_drain(4'b1111, "shuffled");
    endtask

    task automatic test_backpressure();
        start();
        for (int i = 0; i < DEPTH; i++) begin
            wr(i, DATA_W'(32'hA000 + i * 3));
            exp_q.push_back('{idx: ADDR_W'(i), dat: DATA_W'(32'hA000 + i * 3)});
        end
        run_drain(4'b1001, "backpressure");
    endtask

    task automatic test_errors();
        start();
        wr(2, 32'd5);
        wr(2, 32'd9);
        tests_run++;
        if (err !== 2'b01) begin
            tests_failed++;
            $display("FAIL dup_err: err %b, required 01", err);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 2) wr(i, DATA_W'(100 + i));
            exp_q.push_back('{idx: ADDR_W'(i), dat: (i == 2) ? 32'd9 : DATA_W'(100 + i)});
        end
        out_ready = 1'b0;
        wr(3, 32'hDEAD);
        tests_run++;
        if (err !== 2'b11) begin
            tests_failed++;
            $display("FAIL drain_write_err: err %b, required 11", err);
        end
        run_drain(4'b1111, "errors");
        wr(0, 32'h55);
        tests_run++;
        if (err !== 2'b11 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_write: err %b vld %b, required err 11 vld 0", err, out_valid);
        end
    endtask

    task automatic test_abort();
        start();
        for (int i = 0; i < DEPTH; i++) wr(i, DATA_W'(200 + i));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;
        wr(5, 32'h1);
        tests_run++;
        if (out_index !== 3'd3 || out_data !== 32'd203 || err !== 2'b10) begin
            tests_failed++;
            $display("FAIL abort_pos: idx %0d dat %0d err %b, required idx 3 dat 203 err 10",
                     out_index, out_data, err);
        end
        start();
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || err !== 2'b00 || out_index !== '0) begin
            tests_failed++;
            $display("FAIL abort_state: vld %b busy %b err %b idx %0d, required vld 0 busy 1 err 00 idx 0",
                     out_valid, busy, err, out_index);
        end
        for (int i = 0; i < DEPTH; i++) begin
            wr(DEPTH - 1 - i, DATA_W'(300 + DEPTH - 1 - i));
        end
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('{idx: ADDR_W'(i), dat: DATA_W'(300 + i)});
        run_drain(4'b1111, "abort_refill");
    endtask

    task automatic test_reset_mid_drain();
        start();
        for (int i = 0; i < DEPTH; i++) wr(i, DATA_W'(400 + i));
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_index !== '0 || out_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 2'b00 || checksum !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: vld %b dat %0d idx %0d last %b busy %b done %b err %b sum %0d, required all 0",
                     out_valid, out_data, out_index, out_last, busy, done, err, checksum);
        end
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) wr(i, DATA_W'(500 + i));
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_no_tstart: vld %b busy %b err %b, required vld 0 busy 0 err 10",
                     out_valid, busy, err);
        end
        start();
        for (int i = 0; i < DEPTH; i++) begin
            wr(i, DATA_W'(600 + i));
            exp_q.push_back('{idx: ADDR_W'(i), dat: DATA_W'(600 + i)});
        end
        run_drain(4'b0111, "after_reset");
    endtask

    initial begin
        exp_sum = '0;
        test_reset();
        test_in_order();
        test_shuffled();
        test_backpressure();
        test_errors();
        test_abort();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
